// File: rtl/sd_pkg.sv
// Shared constants, state encoding and CRC7 step function for the SD command framer.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_SEND_WRX,
    ST_POLL,
    ST_POLL_WRX,
    ST_TRAIL,
    ST_TRAIL_WRX,
    ST_DONE
  } state_t;

  localparam logic [1:0]  START_BITS       = 2'b01;
  localparam logic [7:0]  FILL_BYTE        = 8'hFF;
  localparam logic [6:0]  CRC7_POLY        = 7'h09;
  localparam logic [7:0]  CRC_BYTE_CMD0    = 8'h95;
  localparam logic [7:0]  CRC_BYTE_CMD8    = 8'h87;
  localparam logic [7:0]  CRC_BYTE_DEFAULT = 8'h01;
  localparam int unsigned FRAME_LAST       = 5;

  // MSB-first CRC7 update over one byte.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator: combinational 8-bit step, registered result.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic [6:0] w_crc_next;

  always_comb w_crc_next = crc7_byte(r_crc, i_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en)  r_crc <= w_crc_next;
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_framer.sv
// SPI-mode SD command framer: sends the 6-byte command, polls for R1, sends Nrc fill.
// Build option SD_CMD_CRC7_EN: compute CRC7 on the fly instead of the fixed CMD0/CMD8 table.
module sd_cmd_framer
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX     = 8,
  parameter int unsigned TRAIL_BYTES = 1
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        CMD_STB,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  output logic        CMD_ACK,
  output logic        BUSY,
  output logic        RSP_STB,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_TIMEOUT,
  output logic        TX_STB,
  output logic [7:0]  TX_DATA,
  input  logic        TX_ACK,
  input  logic        RX_STB,
  input  logic [7:0]  RX_DATA
);

  state_t      r_state,       w_state_n;
  logic [5:0]  r_cmd_idx,     w_cmd_idx_n;
  logic [31:0] r_cmd_arg,     w_cmd_arg_n;
  logic [2:0]  r_byte_idx,    w_byte_idx_n;
  logic [7:0]  r_poll_cnt,    w_poll_cnt_n;
  logic [3:0]  r_trail_cnt,   w_trail_cnt_n;
  logic        r_tx_stb,      w_tx_stb_n;
  logic [7:0]  r_tx_data,     w_tx_data_n;
  logic        r_cmd_ack,     w_cmd_ack_n;
  logic        r_busy,        w_busy_n;
  logic        r_rsp_stb,     w_rsp_stb_n;
  logic [7:0]  r_rsp_data,    w_rsp_data_n;
  logic        r_rsp_timeout, w_rsp_timeout_n;

  logic        w_crc_clr;
  logic        w_crc_en;
  logic [7:0]  w_crc_byte;
  logic [7:0]  w_tx_byte;
  logic        w_byte_done;
  logic        w_rsp_ready;
  logic        w_enter_done;
  logic [7:0]  w_poll_inc;
  logic [3:0]  w_trail_inc;

`ifdef SD_CMD_CRC7_EN
  logic [6:0] w_crc7;

  sd_crc7 u_crc7 (
    .clk    (CLOCK50),
    .rst    (RESET),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_data (w_tx_byte),
    .o_crc  (w_crc7)
  );

  assign w_crc_byte = {w_crc7, 1'b1};
`else
  logic w_unused_crc;
  assign w_unused_crc = w_crc_clr ^ w_crc_en;

  // SPI mode ignores CRC after CMD8, so only CMD0/CMD8 need real values.
  always_comb begin
    w_crc_byte = CRC_BYTE_DEFAULT;
    if (r_cmd_idx == 6'd0)      w_crc_byte = CRC_BYTE_CMD0;
    else if (r_cmd_idx == 6'd8) w_crc_byte = CRC_BYTE_CMD8;
  end
`endif

  // Command frame byte selected by the current byte index.
  always_comb begin
    w_tx_byte = FILL_BYTE;
    case (r_byte_idx)
      3'd0:    w_tx_byte = {START_BITS, r_cmd_idx};
      3'd1:    w_tx_byte = r_cmd_arg[31:24];
      3'd2:    w_tx_byte = r_cmd_arg[23:16];
      3'd3:    w_tx_byte = r_cmd_arg[15:8];
      3'd4:    w_tx_byte = r_cmd_arg[7:0];
      3'd5:    w_tx_byte = w_crc_byte;
      default: w_tx_byte = FILL_BYTE;
    endcase
  end

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_cmd_idx     <= '0;
      r_cmd_arg     <= '0;
      r_byte_idx    <= '0;
      r_poll_cnt    <= '0;
      r_trail_cnt   <= '0;
      r_tx_stb      <= 1'b0;
      r_tx_data     <= FILL_BYTE;
      r_cmd_ack     <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_stb     <= 1'b0;
      r_rsp_data    <= FILL_BYTE;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cmd_idx     <= w_cmd_idx_n;
      r_cmd_arg     <= w_cmd_arg_n;
      r_byte_idx    <= w_byte_idx_n;
      r_poll_cnt    <= w_poll_cnt_n;
      r_trail_cnt   <= w_trail_cnt_n;
      r_tx_stb      <= w_tx_stb_n;
      r_tx_data     <= w_tx_data_n;
      r_cmd_ack     <= w_cmd_ack_n;
      r_busy        <= w_busy_n;
      r_rsp_stb     <= w_rsp_stb_n;
      r_rsp_data    <= w_rsp_data_n;
      r_rsp_timeout <= w_rsp_timeout_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_cmd_idx_n     = r_cmd_idx;
    w_cmd_arg_n     = r_cmd_arg;
    w_byte_idx_n    = r_byte_idx;
    w_poll_cnt_n    = r_poll_cnt;
    w_trail_cnt_n   = r_trail_cnt;
    w_tx_stb_n      = r_tx_stb;
    w_tx_data_n     = r_tx_data;
    w_cmd_ack_n     = 1'b0;
    w_busy_n        = r_busy;
    w_rsp_stb_n     = 1'b0;
    w_rsp_data_n    = r_rsp_data;
    w_rsp_timeout_n = r_rsp_timeout;
    w_crc_clr       = 1'b0;
    w_crc_en        = 1'b0;
    w_byte_done     = 1'b0;
    w_rsp_ready     = 1'b0;
    w_enter_done    = 1'b0;
    w_poll_inc      = (r_poll_cnt == 8'hFF) ? 8'hFF : r_poll_cnt + 8'd1;
    w_trail_inc     = r_trail_cnt + 4'd1;

    case (r_state)
      ST_IDLE: begin
        if (CMD_STB) begin
          w_cmd_idx_n     = CMD_IDX;
          w_cmd_arg_n     = CMD_ARG;
          w_byte_idx_n    = '0;
          w_poll_cnt_n    = '0;
          w_trail_cnt_n   = '0;
          w_rsp_timeout_n = 1'b0;
          w_cmd_ack_n     = 1'b1;
          w_busy_n        = 1'b1;
          w_crc_clr       = 1'b1;
          w_state_n       = ST_SEND;
        end
      end
      // Load a byte, then hold it until the controller acks.
      ST_SEND, ST_POLL, ST_TRAIL: begin
        if (!r_tx_stb) begin
          w_tx_stb_n  = 1'b1;
          w_tx_data_n = (r_state == ST_SEND) ? w_tx_byte : FILL_BYTE;
          w_crc_en    = (r_state == ST_SEND) && (r_byte_idx < 3'(FRAME_LAST));
        end else if (TX_ACK) begin
          w_tx_stb_n = 1'b0;
          if (RX_STB) w_byte_done = 1'b1;
          else if (r_state == ST_SEND) w_state_n = ST_SEND_WRX;
          else if (r_state == ST_POLL) w_state_n = ST_POLL_WRX;
          else                         w_state_n = ST_TRAIL_WRX;
        end
      end
      ST_SEND_WRX, ST_POLL_WRX, ST_TRAIL_WRX: w_byte_done = RX_STB;
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase

    // Received byte completes the current transfer.
    if (w_byte_done) begin
      case (r_state)
        ST_SEND, ST_SEND_WRX: begin
          if (r_byte_idx == 3'(FRAME_LAST)) begin
            w_state_n = ST_POLL;
          end else begin
            w_byte_idx_n = r_byte_idx + 3'd1;
            w_state_n    = ST_SEND;
          end
        end
        ST_POLL, ST_POLL_WRX: begin
          if (!RX_DATA[7]) begin
            w_rsp_data_n    = RX_DATA;
            w_rsp_timeout_n = 1'b0;
            w_rsp_ready     = 1'b1;
          end else begin
            w_poll_cnt_n = w_poll_inc;
            if (w_poll_inc == 8'(NCR_MAX)) begin
              w_rsp_data_n    = FILL_BYTE;
              w_rsp_timeout_n = 1'b1;
              w_rsp_ready     = 1'b1;
            end else begin
              w_state_n = ST_POLL;
            end
          end
        end
        default: begin
          w_trail_cnt_n = w_trail_inc;
          if (w_trail_inc == 4'(TRAIL_BYTES)) w_enter_done = 1'b1;
          else                                w_state_n    = ST_TRAIL;
        end
      endcase
    end

    if (w_rsp_ready) begin
      if (TRAIL_BYTES == 0) w_enter_done = 1'b1;
      else                  w_state_n    = ST_TRAIL;
    end

    if (w_enter_done) begin
      w_state_n   = ST_DONE;
      w_rsp_stb_n = 1'b1;
      w_busy_n    = 1'b0;
    end
  end

  assign CMD_ACK     = r_cmd_ack;
  assign BUSY        = r_busy;
  assign RSP_STB     = r_rsp_stb;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_TIMEOUT = r_rsp_timeout;
  assign TX_STB      = r_tx_stb;
  assign TX_DATA     = r_tx_data;

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
- Command-layer stage directly upstream of the SPI byte controller (SPI_cont) in the SD card driver.
- Accepts an SD command index plus a 32-bit argument and frames the 6-byte SPI-mode command, including CRC7.
- Streams the frame through the byte-level SPI strobe/ack interface, then polls with 0xFF fill bytes for the R1 response.
- Returns R1 or a timeout flag to the card_driver control logic.

Parameters:
- NCR_MAX, 8: maximum number of 0xFF poll bytes before declaring a response timeout (range 1..255).
- TRAIL_BYTES, 1: number of 0xFF bytes sent after the response (Nrc gap) before returning to IDLE (range 0..15).

Ports:
- CLOCK50  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CMD_STB  in  1  command request; sampled only in IDLE.
- CMD_IDX  in  6  command index, captured with CMD_STB.
- CMD_ARG  in  32  command argument, captured with CMD_STB.
- CMD_ACK  out  1  one-cycle pulse when a command is accepted.
- BUSY  out  1  high from acceptance until return to IDLE.
- RSP_STB  out  1  one-cycle pulse; RSP_DATA and RSP_TIMEOUT valid in that cycle.
- RSP_DATA  out  8  R1 byte, or 0xFF on timeout.
- RSP_TIMEOUT  out  1  set together with RSP_STB when NCR_MAX is exhausted.
- TX_STB  out  1  byte request to SPI_cont; held high until TX_ACK.
- TX_DATA  out  8  byte to shift out; stable while TX_STB is high.
- TX_ACK  in  1  SPI_cont has taken the byte.
- RX_STB  in  1  one-cycle pulse; the full-duplex received byte is complete.
- RX_DATA  in  8  received byte, valid with RX_STB.

Behaviour:
- Reset values: all outputs 0, except TX_DATA=0xFF and RSP_DATA=0xFF. State is IDLE; counters and CRC register are 0.
- Reset mid-operation aborts immediately: TX_STB drops asynchronously and no RSP_STB is issued.
- IDLE: CMD_STB=1 in cycle N captures CMD_IDX/CMD_ARG. CMD_ACK pulses and BUSY rises in cycle N+1; state moves to SEND with byte index 0. CMD_STB while BUSY is ignored (no ACK, nothing queued).
- SEND, frame order:
  - byte0 = {2'b01, CMD_IDX}
  - bytes 1..4 = CMD_ARG[31:24], [23:16], [15:8], [7:0]
  - byte5 = {CRC7, 1'b1}
- TX_STB is asserted the cycle after entry and held until TX_ACK. TX_STB drops in the cycle after TX_ACK.
- After TX_ACK the block waits for RX_STB; the received byte is discarded in SEND. The next byte is then presented one cycle later.
- TX_ACK and RX_STB in the same cycle are legal and are treated as ack-then-rx.
- CRC7 (poly x^7+x^3+1, init 0) is updated byte-serially with each of bytes 0..4 as it is loaded into TX_DATA, so it is final before byte5.
- POLL: sends 0xFF using the same handshake. On each RX_STB:
  - RX_DATA[7]==0: latch it as R1 and go to TRAIL.
  - otherwise increment the poll counter.
  - counter == NCR_MAX: RSP_DATA=0xFF, RSP_TIMEOUT=1, go to TRAIL.
- The poll counter is 8 bits and saturates; it cannot wrap.
- TRAIL: sends TRAIL_BYTES 0xFF bytes, with RX ignored, then goes to DONE. TRAIL_BYTES=0 skips directly to DONE.
- DONE: RSP_STB pulses for one cycle. BUSY falls in the same cycle; state returns to IDLE. A new CMD_STB is accepted from the following cycle.
- States: IDLE, SEND, SEND_WRX, POLL, POLL_WRX, TRAIL, TRAIL_WRX, DONE.
- A stray RX_STB in IDLE is ignored.

Optional Feature:
- Macro SD_CMD_CRC7_EN.
- Defined: CRC7 is computed as described for every command.
- Undefined: no CRC logic; byte5 comes from a fixed table. CMD0 gives 0x95, CMD8 gives 0x87, all others give 0x01. This is valid because SPI mode does not check CRC after CMD8.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding constants
  - start-bits constant 2'b01
  - fill byte 0xFF
  - CRC7 polynomial 7'h09
  - fixed CRC bytes 0x95 and 0x87
- One sub-module, sd_crc7: byte-serial CRC7 with clear, enable and 8-bit data in, 7-bit CRC out; combinational over 8 bits with a registered result.
- sd_crc7 is instantiated only under SD_CMD_CRC7_EN.

Test Plan:
1. CMD0, ARG=0x00000000; SPI model answers 0xFF, 0xFF, 0x01 -> TX bytes 40 00 00 00 00 95, then 3 poll bytes and 1 trail byte. RSP_STB with RSP_DATA=0x01, RSP_TIMEOUT=0.
2. CMD8, ARG=0x000001AA; response 0x01 on the first poll -> TX bytes 48 00 00 01 AA 87. Check this both with and without SD_CMD_CRC7_EN.
3. CMD55, all RX bytes 0xFF, NCR_MAX=8 -> exactly 8 poll bytes. RSP_DATA=0xFF, RSP_TIMEOUT=1, BUSY low in the RSP_STB cycle.
4. CMD_STB pulsed again during SEND -> no second CMD_ACK and TX frame unaltered. A CMD_STB the cycle after RSP_STB is accepted.
5. Assert RESET during POLL byte 2 -> TX_STB=0, BUSY=0, no RSP_STB. A following CMD0 completes normally.
6. SPI model with zero-latency TX_ACK+RX_STB in the same cycle, and with 20-cycle stalls -> identical byte sequence. TX_DATA stays stable while TX_STB is high.
